// File: rtl/dcsa_result_checker.sv
// Result checker for the duplicated carry-select adder: dual-rail and parity checks,
// consecutive-error FSM with sticky alarm. Define DCSA_CHECKER_STATS_EN to add beat_count.
module dcsa_result_checker #(
  parameter int WIDTH      = 64,
  parameter int ERR_THRESH = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] s_invert,
  input  logic             papb,
  input  logic             pab,
  input  logic             clear_alarm,
  output logic             out_valid,
  output logic [WIDTH-1:0] s_out,
  output logic             err_dup,
  output logic             err_par,
  output logic             alarm,
`ifdef DCSA_CHECKER_STATS_EN
  output logic [CNT_W-1:0] beat_count,
`endif
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_ALARM} state_t;

  localparam logic [3:0] THRESH4 = 4'(ERR_THRESH);

  logic             v1_q;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] si1_q;
  logic             papb1_q;
  logic             pab1_q;

  logic             outValid_q;
  logic [WIDTH-1:0] sOut_q;
  logic             errDup_q;
  logic             errPar_q;
  logic [CNT_W-1:0] errCount_q;

  state_t           state_q, state_d;
  logic [3:0]       consec_q, consec_d;

  logic             dupBad;
  logic             parBad;
  logic             errBeat;

  // Stage 1: capture the raw adder outputs; data holds on idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      s1_q    <= '0;
      si1_q   <= '0;
      papb1_q <= 1'b0;
      pab1_q  <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_q    <= s;
        si1_q   <= s_invert;
        papb1_q <= papb;
        pab1_q  <= pab;
      end
    end
  end

  // Each predicted parity bit is checked against its own rail
  assign dupBad  = (s1_q != ~si1_q);
  assign parBad  = ((^s1_q) != papb1_q) || ((^si1_q) != pab1_q);
  assign errBeat = v1_q && (dupBad || parBad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      sOut_q     <= '0;
      errDup_q   <= 1'b0;
      errPar_q   <= 1'b0;
      errCount_q <= '0;
    end else begin
      outValid_q <= v1_q;
      errDup_q   <= v1_q && dupBad;
      errPar_q   <= v1_q && parBad;
      if (v1_q) begin
        sOut_q <= s1_q;
      end
      if (errBeat && (errCount_q != {CNT_W{1'b1}})) begin
        errCount_q <= errCount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OK;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
    end
  end

  // clear_alarm first rewinds to OK, then any beat in stage 2 is applied from there
  always_comb begin
    state_t     stBase;
    logic [3:0] consecBase;
    stBase     = state_q;
    consecBase = consec_q;
    if (clear_alarm) begin
      stBase     = ST_OK;
      consecBase = '0;
    end
    state_d  = stBase;
    consec_d = consecBase;
    if (v1_q) begin
      case (stBase)
        ST_OK: begin
          if (errBeat) begin
            if (ERR_THRESH == 1) begin
              state_d = ST_ALARM;
            end else begin
              state_d  = ST_SUSPECT;
              consec_d = 4'd1;
            end
          end
        end
        ST_SUSPECT: begin
          if (errBeat) begin
            consec_d = consecBase + 4'd1;
            if ((consecBase + 4'd1) == THRESH4) begin
              state_d = ST_ALARM;
            end
          end else begin
            state_d  = ST_OK;
            consec_d = '0;
          end
        end
        ST_ALARM: state_d = ST_ALARM;
        default: begin
          state_d  = ST_OK;
          consec_d = '0;
        end
      endcase
    end
  end

`ifdef DCSA_CHECKER_STATS_EN
  logic [CNT_W-1:0] beatCount_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beatCount_q <= '0;
    end else if (v1_q && (beatCount_q != {CNT_W{1'b1}})) begin
      beatCount_q <= beatCount_q + 1'b1;
    end
  end

  assign beat_count = beatCount_q;
`endif

  assign out_valid = outValid_q;
  assign s_out     = sOut_q;
  assign err_dup   = errDup_q;
  assign err_par   = errPar_q;
  assign err_count = errCount_q;
  assign alarm     = (state_q == ST_ALARM);

endmodule
